// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for the 16-bit pipelined CPU.
// Tracks the PC, fetches with a ready handshake, honours stall/flush and stops after HLT.
module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [15:0] branch_target,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        imem_ready,
    output logic [15:0] IF_ID_instr,
    output logic [15:0] IF_ID_pc_increment,
    output logic        IF_ID_valid,
    output logic        halted
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    localparam logic [3:0] HLT_OPCODE = 4'b1111;

    state_t      state;
    logic [15:0] pc_p0;
    logic [15:0] pc_inc_p0;
    logic [15:0] instr_p1;
    logic [15:0] pc_inc_p1;
    logic        vld_p1;

    // PC arithmetic wraps modulo 2^16; bit 0 is kept clear everywhere the PC is loaded.
    function automatic logic [15:0] even_addr(input logic [15:0] addr);
        return {addr[15:1], 1'b0};
    endfunction

    assign imem_addr = pc_p0;
    assign pc_inc_p0 = pc_p0 + 16'd2;

    // IF -> IF/ID boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            pc_p0     <= even_addr(RESET_PC);
            instr_p1  <= NOP_INSTR;
            pc_inc_p1 <= 16'h0000;
            vld_p1    <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (stall) begin
                        // decode's flush is not trustworthy while the pipe is stalled
                    end else if (flush) begin
                        pc_p0     <= even_addr(branch_target);
                        instr_p1  <= NOP_INSTR;
                        pc_inc_p1 <= 16'h0000;
                        vld_p1    <= 1'b0;
                    end else if (!imem_ready) begin
                        instr_p1  <= NOP_INSTR;
                        pc_inc_p1 <= 16'h0000;
                        vld_p1    <= 1'b0;
                    end else begin
                        instr_p1  <= imem_data;
                        pc_inc_p1 <= pc_inc_p0;
                        vld_p1    <= 1'b1;
                        if (imem_data[15:12] == HLT_OPCODE) begin
                            state <= HALTED;
                        end else begin
                            pc_p0 <= pc_inc_p0;
                        end
                    end
                end
                HALTED: begin
                    if (!stall) begin
                        instr_p1  <= NOP_INSTR;
                        pc_inc_p1 <= 16'h0000;
                        vld_p1    <= 1'b0;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign IF_ID_instr        = instr_p1;
    assign IF_ID_pc_increment = pc_inc_p1;
    assign IF_ID_valid        = vld_p1;
    assign halted             = (state == HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed cycles push hand-computed IF/ID and PC
// expectations; an independent monitor pops and compares after every rising edge.
module tb_fetch_stage;

    typedef struct {
        string       name;
        logic [15:0] instr;
        logic [15:0] inc;
        logic        vld;
        logic        hlt;
        logic [15:0] addr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] branch_target = 16'h0000;
    logic [15:0] imem_addr;
    logic [15:0] imem_data = 16'h0000;
    logic        imem_ready = 1'b0;
    logic [15:0] IF_ID_instr;
    logic [15:0] IF_ID_pc_increment;
    logic        IF_ID_valid;
    logic        halted;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    fetch_stage #(
        .RESET_PC (16'h0000),
        .NOP_INSTR(16'h0000)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .stall             (stall),
        .flush             (flush),
        .branch_target     (branch_target),
        .imem_addr         (imem_addr),
        .imem_data         (imem_data),
        .imem_ready        (imem_ready),
        .IF_ID_instr       (IF_ID_instr),
        .IF_ID_pc_increment(IF_ID_pc_increment),
        .IF_ID_valid       (IF_ID_valid),
        .halted            (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input string field,
                       input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %h, expected %h", name, field, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and record what must be seen after the next rising edge.
    task automatic cyc(input string name, input logic r, input logic st, input logic fl,
                       input logic [15:0] bt, input logic rdy, input logic [15:0] data,
                       input logic [15:0] e_instr, input logic [15:0] e_inc,
                       input logic e_vld, input logic e_hlt, input logic [15:0] e_addr);
        exp_t e;
        @(negedge clk);
        rst           = r;
        stall         = st;
        flush         = fl;
        branch_target = bt;
        imem_ready    = rdy;
        imem_data     = data;
        e.name  = name;
        e.instr = e_instr;
        e.inc   = e_inc;
        e.vld   = e_vld;
        e.hlt   = e_hlt;
        e.addr  = e_addr;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk(e.name, "instr", IF_ID_instr, e.instr);
                chk(e.name, "pc_inc", IF_ID_pc_increment, e.inc);
                chk(e.name, "valid", {15'd0, IF_ID_valid}, {15'd0, e.vld});
                chk(e.name, "halted", {15'd0, halted}, {15'd0, e.hlt});
                chk(e.name, "imem_addr", imem_addr, e.addr);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        //   name         rst st fl bt        rdy data      instr     inc       v  h  addr
        cyc("reset",      1, 0, 0, 16'h0000, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000);
        cyc("fetch0",     0, 0, 0, 16'h0000, 1, 16'h0123, 16'h0123, 16'h0002, 1, 0, 16'h0002);
        cyc("fetch2",     0, 0, 0, 16'h0000, 1, 16'h1456, 16'h1456, 16'h0004, 1, 0, 16'h0004);
        cyc("stall_a",    0, 1, 0, 16'h0000, 1, 16'h2789, 16'h1456, 16'h0004, 1, 0, 16'h0004);
        cyc("stall_b",    0, 1, 0, 16'h0000, 1, 16'h2789, 16'h1456, 16'h0004, 1, 0, 16'h0004);
        cyc("fetch4",     0, 0, 0, 16'h0000, 1, 16'h2789, 16'h2789, 16'h0006, 1, 0, 16'h0006);
        cyc("flush_stl",  0, 1, 1, 16'h0041, 1, 16'h1111, 16'h2789, 16'h0006, 1, 0, 16'h0006);
        cyc("flush",      0, 0, 1, 16'h0041, 1, 16'h1111, 16'h0000, 16'h0000, 0, 0, 16'h0040);
        cyc("fetch40",    0, 0, 0, 16'h0000, 1, 16'h3333, 16'h3333, 16'h0042, 1, 0, 16'h0042);
        cyc("nrdy_a",     0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0042);
        cyc("nrdy_b",     0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0042);
        cyc("nrdy_c",     0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0042);
        cyc("hlt_flush",  0, 0, 1, 16'h0010, 1, 16'hF000, 16'h0000, 16'h0000, 0, 0, 16'h0010);
        cyc("to_08",      0, 0, 1, 16'h0009, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0008);
        cyc("hlt",        0, 0, 0, 16'h0000, 1, 16'hF000, 16'hF000, 16'h000A, 1, 1, 16'h0008);
        cyc("hlt_stall",  0, 1, 0, 16'h0000, 1, 16'h4444, 16'hF000, 16'h000A, 1, 1, 16'h0008);
        cyc("hlt_flush2", 0, 0, 1, 16'h0020, 1, 16'h4444, 16'h0000, 16'h0000, 0, 1, 16'h0008);
        cyc("hlt_idle",   0, 0, 0, 16'h0000, 1, 16'h5555, 16'h0000, 16'h0000, 0, 1, 16'h0008);
        cyc("reset2",     1, 0, 0, 16'h0000, 1, 16'h5555, 16'h0000, 16'h0000, 0, 0, 16'h0000);
        cyc("to_fffe",    0, 0, 1, 16'hFFFE, 1, 16'h5555, 16'h0000, 16'h0000, 0, 0, 16'hFFFE);
        cyc("wrap",       0, 0, 0, 16'h0000, 1, 16'h6666, 16'h6666, 16'h0000, 1, 0, 16'h0000);
        cyc("after_wrap", 0, 0, 0, 16'h0000, 1, 16'h7777, 16'h7777, 16'h0002, 1, 0, 16'h0002);
        cyc("hlt_in_stl", 0, 1, 0, 16'h0000, 1, 16'hF000, 16'h7777, 16'h0002, 1, 0, 16'h0002);
        cyc("post_stl",   0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0002);
        @(negedge clk);
        @(negedge clk);
        chk("drain", "queue_left", 16'(exp_q.size()), 16'h0000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
